// File: rtl/kb_scan_controller.sv
// PS/2 keyboard receiver: synchronizes the keyboard bus, deframes 11-bit
// frames, decodes E0/F0 prefixes and tracks two extended arrow keys as levels.
module kb_scan_controller #(
    parameter int          TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  UP_CODE        = 8'h75,
    parameter logic [7:0]  DOWN_CODE      = 8'h72
) (
    input  logic       sysClock,
    input  logic       reset,
    input  logic       kbClock,
    input  logic       kbData,
    output logic       keyValid,
    output logic [7:0] keyCode,
    output logic       keyBreak,
    output logic       keyExtended,
    output logic       frameError,
    output logic       upButton,
    output logic       downButton
);

    localparam int             TW      = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0]  TO_MAX  = {TW{1'b1}};

    localparam logic [7:0] EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    logic          clk_meta, clk_sync, clk_prev;
    logic          data_meta, data_sync;
    logic          fall;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift_reg;
    logic          parity_bit;
    logic [TW-1:0] to_cnt;

    logic          ext_flag;
    logic          break_flag;

    logic          timeout_hit;
    logic          stop_edge;
    logic          frame_ok;
    logic          frame_good;
    logic          frame_bad;

    // NOTE: synchronizer flops reset to 1 (idle bus) so leaving reset never
    // looks like a falling kbClock edge.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= kbClock;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= kbData;
            data_sync <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_sync;

    // An edge arriving on the expiry cycle wins over the timeout.
    always_comb begin
        timeout_hit = (state != ST_IDLE) && !fall && (to_cnt == TO_LAST);
        stop_edge   = fall && (state == ST_STOP);
        frame_ok    = data_sync && (^{shift_reg, parity_bit});
        frame_good  = stop_edge && frame_ok;
        frame_bad   = stop_edge && !frame_ok;
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge sysClock) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
        end else if (timeout_hit) begin
            state <= ST_IDLE;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!data_sync) begin
                        state   <= ST_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_reg <= {data_sync, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state <= ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_bit <= data_sync;
                    state      <= ST_STOP;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysClock) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (fall || (state == ST_IDLE)) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    always_ff @(posedge sysClock) begin
        if (reset) begin
            ext_flag    <= 1'b0;
            break_flag  <= 1'b0;
            keyValid    <= 1'b0;
            keyCode     <= 8'h00;
            keyBreak    <= 1'b0;
            keyExtended <= 1'b0;
            frameError  <= 1'b0;
            upButton    <= 1'b0;
            downButton  <= 1'b0;
        end else begin
            keyValid   <= 1'b0;
            frameError <= 1'b0;
            if (timeout_hit || frame_bad) begin
                frameError <= 1'b1;
                ext_flag   <= 1'b0;
                break_flag <= 1'b0;
            end else if (frame_good) begin
                if (shift_reg == EXT_PREFIX) begin
                    ext_flag <= 1'b1;
                end else if (shift_reg == BREAK_PREFIX) begin
                    break_flag <= 1'b1;
                end else begin
                    keyValid    <= 1'b1;
                    keyCode     <= shift_reg;
                    keyBreak    <= break_flag;
                    keyExtended <= ext_flag;
                    ext_flag    <= 1'b0;
                    break_flag  <= 1'b0;
                    // Keypad (non-extended) variants share these codes.
                    if (ext_flag && (shift_reg == UP_CODE)) begin
                        upButton <= !break_flag;
                    end
                    if (ext_flag && (shift_reg == DOWN_CODE)) begin
                        downButton <= !break_flag;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kb_scan_controller.sv
// Directed bench for kb_scan_controller: drives PS/2 frames bit by bit and
// checks decoded events, error pulses and button levels.
module tb_kb_scan_controller;

    localparam int TO_CYC = 200;

    logic       sysClock = 1'b0;
    logic       reset    = 1'b1;
    logic       kbClock  = 1'b1;
    logic       kbData   = 1'b1;
    logic       keyValid;
    logic [7:0] keyCode;
    logic       keyBreak;
    logic       keyExtended;
    logic       frameError;
    logic       upButton;
    logic       downButton;

    int compared   = 0;
    int mismatched = 0;

    int         kv_total = 0;
    int         fe_total = 0;
    int         down_hi  = 0;
    int         down_lo  = 0;
    logic [7:0] kv_code  = 8'h00;
    logic       kv_break = 1'b0;
    logic       kv_ext   = 1'b0;
    logic       kv_up    = 1'b0;
    logic       kv_down  = 1'b0;

    int kv0, fe0, dh0, dl0;

    kb_scan_controller #(
        .TIMEOUT_CYCLES(TO_CYC),
        .UP_CODE       (8'h75),
        .DOWN_CODE     (8'h72)
    ) dut (
        .sysClock   (sysClock),
        .reset      (reset),
        .kbClock    (kbClock),
        .kbData     (kbData),
        .keyValid   (keyValid),
        .keyCode    (keyCode),
        .keyBreak   (keyBreak),
        .keyExtended(keyExtended),
        .frameError (frameError),
        .upButton   (upButton),
        .downButton (downButton)
    );

    always #5 sysClock = ~sysClock;

    // Pulse and level observers; the initial block compares their deltas.
    always @(negedge sysClock) begin
        if (keyValid) begin
            kv_total = kv_total + 1;
            kv_code  = keyCode;
            kv_break = keyBreak;
            kv_ext   = keyExtended;
            kv_up    = upButton;
            kv_down  = downButton;
        end
        if (frameError) fe_total = fe_total + 1;
        if (downButton) down_hi = down_hi + 1;
        else            down_lo = down_lo + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        kv0 = kv_total;
        fe0 = fe_total;
        dh0 = down_hi;
        dl0 = down_lo;
    endtask

    task automatic ps2_bit(input logic b);
        kbData = b;
        repeat (4) @(negedge sysClock);
        kbClock = 1'b0;
        repeat (8) @(negedge sysClock);
        kbClock = 1'b1;
        repeat (4) @(negedge sysClock);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop_bit);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(stop_bit);
        kbData = 1'b1;
        repeat (10) @(negedge sysClock);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge sysClock);
        check("rst_keyValid", keyValid, 1'b0);
        check("rst_keyCode", keyCode, 8'h00);
        check("rst_keyBreak", keyBreak, 1'b0);
        check("rst_keyExtended", keyExtended, 1'b0);
        check("rst_frameError", frameError, 1'b0);
        check("rst_upButton", upButton, 1'b0);
        check("rst_downButton", downButton, 1'b0);
        reset = 1'b0;
        repeat (5) @(negedge sysClock);

        // Extended up press
        mark();
        send_good(8'hE0);
        send_good(8'h75);
        check("up_make_kv", kv_total - kv0, 1);
        check("up_make_code", kv_code, 8'h75);
        check("up_make_ext", kv_ext, 1'b1);
        check("up_make_brk", kv_break, 1'b0);
        check("up_make_btn_same_cycle", kv_up, 1'b1);
        check("up_make_btn", upButton, 1'b1);
        check("up_make_hold_code", keyCode, 8'h75);
        check("up_make_fe", fe_total - fe0, 0);

        // Keypad release of the same code leaves the arrow held
        mark();
        send_good(8'hF0);
        send_good(8'h75);
        check("kp_rel_kv", kv_total - kv0, 1);
        check("kp_rel_brk", keyBreak, 1'b1);
        check("kp_rel_ext", keyExtended, 1'b0);
        check("kp_rel_up", upButton, 1'b1);

        // Extended up release
        mark();
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h75);
        check("up_brk_kv", kv_total - kv0, 1);
        check("up_brk_brk", keyBreak, 1'b1);
        check("up_brk_ext", keyExtended, 1'b1);
        check("up_brk_up", upButton, 1'b0);
        check("up_brk_down_never", down_hi - dh0, 0);

        // Bad parity after E0, then a clean 1C
        mark();
        send_good(8'hE0);
        send_frame(8'h1C, 1'b1, 1'b1);
        check("par_err_fe", fe_total - fe0, 1);
        check("par_err_kv", kv_total - kv0, 0);
        send_good(8'h1C);
        check("par_next_kv", kv_total - kv0, 1);
        check("par_next_code", keyCode, 8'h1C);
        check("par_next_ext", keyExtended, 1'b0);
        check("par_next_brk", keyBreak, 1'b0);

        // Stop bit low
        mark();
        send_frame(8'h22, 1'b0, 1'b0);
        check("stop_err_fe", fe_total - fe0, 1);
        check("stop_err_kv", kv_total - kv0, 0);
        check("stop_err_code_hold", keyCode, 8'h1C);

        // Timeout mid-frame after an E0 prefix
        mark();
        send_good(8'hE0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        repeat (170) @(negedge sysClock);
        check("to_not_early", fe_total - fe0, 0);
        repeat (60) @(negedge sysClock);
        check("to_fe", fe_total - fe0, 1);
        check("to_kv", kv_total - kv0, 0);
        send_good(8'h72);
        check("to_next_kv", kv_total - kv0, 1);
        check("to_next_code", keyCode, 8'h72);
        check("to_next_ext", keyExtended, 1'b0);
        check("to_next_down", downButton, 1'b0);

        // Reset in the middle of the frame following E0
        mark();
        send_good(8'hE0);
        ps2_bit(1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge sysClock);
        check("mid_rst_code", keyCode, 8'h00);
        reset = 1'b0;
        repeat (TO_CYC + 50) @(negedge sysClock);
        check("mid_rst_no_kv", kv_total - kv0, 0);
        check("mid_rst_no_fe", fe_total - fe0, 0);
        send_good(8'h72);
        check("mid_rst_kv", kv_total - kv0, 1);
        check("mid_rst_code72", keyCode, 8'h72);
        check("mid_rst_ext", keyExtended, 1'b0);
        check("mid_rst_down", downButton, 1'b0);

        // Typematic extended down
        mark();
        send_good(8'hE0);
        send_good(8'h72);
        check("typ1_down", downButton, 1'b1);
        check("typ1_down_same_cycle", kv_down, 1'b1);
        dl0 = down_lo;
        send_good(8'hE0);
        send_good(8'h72);
        check("typ_kv", kv_total - kv0, 2);
        check("typ_down_steady", down_lo - dl0, 0);
        check("typ2_down", downButton, 1'b1);
        check("typ_up", upButton, 1'b0);

        // Release down
        mark();
        send_good(8'hE0);
        send_good(8'hF0);
        send_good(8'h72);
        check("down_rel_kv", kv_total - kv0, 1);
        check("down_rel_down", downButton, 1'b0);
        check("down_rel_brk", keyBreak, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/kb_scan_controller.md
KB_SCAN_CONTROLLER -- requirements
Module: kb_scan_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 50000, SHALL set the sysClock cycles allowed between kbClock falling edges inside a frame.
REQ-002 Parameter UP_CODE, default 8'h75, SHALL be the extended scan code driving upButton.
REQ-003 Parameter DOWN_CODE, default 8'h72, SHALL be the extended scan code driving downButton.
REQ-004 sysClock  in  1  SHALL be the single system clock; all state updates occur on its rising edge.
REQ-005 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-006 kbClock  in  1  SHALL be the asynchronous PS/2 clock from the keyboard.
REQ-007 kbData  in  1  SHALL be the asynchronous PS/2 data line from the keyboard.
REQ-008 keyValid  out  1  SHALL be a one-cycle pulse marking a completed non-prefix key event.
REQ-009 keyCode  out  8  SHALL hold the scan code of the most recent key event.
REQ-010 keyBreak  out  1  SHALL be 1 when that event was preceded by F0 (release).
REQ-011 keyExtended  out  1  SHALL be 1 when that event was preceded by E0.
REQ-012 frameError  out  1  SHALL be a one-cycle pulse on parity, stop-bit or timeout failure.
REQ-013 upButton  out  1  SHALL be a level, 1 while the extended UP_CODE key is held.
REQ-014 downButton  out  1  SHALL be a level, 1 while the extended DOWN_CODE key is held.

Function
REQ-015 kbClock and kbData SHALL each pass through a two-flop synchronizer before use.
REQ-016 A falling edge SHALL be detected as synchronized kbClock 1 in the previous cycle and 0 in the current cycle; kbData is sampled that same cycle.
REQ-017 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP.
REQ-018 IDLE: falling edge with kbData=0 -> DATA, bit counter=0; falling edge with kbData=1 -> stay IDLE, no error.
REQ-019 DATA: each falling edge shifts kbData into the shift register LSB-first; after the 8th bit -> PARITY.
REQ-020 PARITY: falling edge captures parity bit -> STOP; frame parity is valid when the 8 data bits plus the parity bit contain an odd number of ones.
REQ-021 STOP: falling edge -> IDLE; frame is good only when stop bit=1 and parity valid, otherwise frameError pulses.
REQ-022 A timeout counter SHALL clear on every falling edge and while in IDLE, and increment otherwise; reaching TIMEOUT_CYCLES-1 outside IDLE -> IDLE with a frameError pulse.
REQ-023 A falling edge in the same cycle as timeout expiry SHALL be processed normally; no timeout occurs.
REQ-024 Good frame 8'hE0 SHALL set extFlag; good frame 8'hF0 SHALL set breakFlag; neither produces keyValid.
REQ-025 Any other good frame SHALL pulse keyValid the cycle after the stop-bit edge, with keyCode=byte, keyBreak=breakFlag, keyExtended=extFlag; both flags then clear.
REQ-026 frameError SHALL clear extFlag and breakFlag.
REQ-027 keyCode, keyBreak and keyExtended SHALL hold their values until the next keyValid.
REQ-028 On a keyValid event with keyExtended=1 and keyCode=UP_CODE, upButton SHALL become !keyBreak in the same cycle as keyValid; DOWN_CODE likewise drives downButton.
REQ-029 Non-extended UP_CODE and DOWN_CODE (keypad keys) SHALL NOT affect the button outputs.
REQ-030 Repeated make codes (typematic) SHALL re-pulse keyValid and leave held buttons at 1.
REQ-031 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES)+1 bits, and it saturates rather than wraps.

Reset
REQ-032 Reset SHALL force FSM=IDLE; bit counter, shift register, timeout counter, extFlag and breakFlag=0.
REQ-033 Reset SHALL force keyValid=0, keyCode=8'h00, keyBreak=0, keyExtended=0, frameError=0, upButton=0, downButton=0.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no keyValid or frameError pulse; the synchronizer flops reset to 1 (idle bus), so no false edge is seen after reset.

Verification
REQ-035 Frames E0,75 -> one keyValid, keyCode=75, keyExtended=1, keyBreak=0, upButton=1.
REQ-036 Frames E0,F0,75 -> keyValid, keyBreak=1, keyExtended=1, upButton=0; downButton stays 0 throughout.
REQ-037 Frame 1C with the parity bit flipped -> frameError pulse, no keyValid; the following good 1C -> keyValid, keyCode=1C, flags 0.
REQ-038 Start plus 4 data bits then kbClock held high for TIMEOUT_CYCLES -> frameError; the next full frame 72 -> keyValid, keyCode=72, keyExtended=0, downButton=0.
REQ-039 E0 then reset mid-frame, then frames 72 -> keyExtended=0 (flag cleared), downButton=0, no spurious pulses around reset.
REQ-040 Frame E0,72 followed by a second E0,72 (typematic) -> two keyValid pulses, downButton=1 continuously.
